// File: rtl/alu_wb_stage_if.sv
// rtl/alu_wb_stage_if.sv - ALU result handshake in, register-file writeback handshake out
interface alu_wb_stage_if #(
    parameter int DW = 6,
    parameter int AW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    alu_cmd;
    logic [DW-1:0] rslt;
    logic          sc_o;
    logic          pari;
    logic          zero;
    logic          neq;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_we;

    modport slave (
        input  in_valid, alu_cmd, rslt, sc_o, pari, zero, neq, wr_addr, wr_en, out_ready,
        output in_ready, out_valid, out_data, out_addr, out_we
    );

    modport master (
        output in_valid, alu_cmd, rslt, sc_o, pari, zero, neq, wr_addr, wr_en, out_ready,
        input  in_ready, out_valid, out_data, out_addr, out_we
    );
endinterface

// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU writeback stage: 2-entry skid FIFO, carry/flag registers, retire counter
module alu_wb_stage #(
    parameter int DW = 6,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    alu_wb_stage_if.slave bus,
    output logic          sc_q,
    output logic [2:0]    flags_q,
    output logic [7:0]    retire_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [1:0] CMD_NOP = 2'b11;

    state_t        state_q, state_d;
    logic          in_ready_q;
    logic [DW-1:0] head_data_q, tail_data_q;
    logic [AW-1:0] head_addr_q, tail_addr_q;
    logic          head_we_q, tail_we_q;
    logic [7:0]    retire_cnt_q;

    logic          accept;
    logic          drain;
    logic          new_we;
    logic          load_head_new;
    logic          load_head_tail;
    logic          load_tail;

    // in_ready_q is low only in FULL (and until the first edge after reset),
    // so an accept can never coincide with FULL.
    assign accept = bus.in_valid && in_ready_q;
    assign drain  = (state_q != EMPTY) && bus.out_ready;
    assign new_we = bus.wr_en && (bus.alu_cmd != CMD_NOP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_head_new  = 1'b0;
        load_head_tail = 1'b0;
        load_tail      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d       = ONE;
                    load_head_new = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_head_new = 1'b1;
                end else if (accept) begin
                    state_d   = FULL;
                    load_tail = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d        = ONE;
                    load_head_tail = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= (state_d != FULL);
        end
    end

    // Head slot drives the writeback outputs directly; tail is the skid slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_data_q <= '0;
            head_addr_q <= '0;
            head_we_q   <= 1'b0;
        end else if (load_head_new) begin
            head_data_q <= bus.rslt;
            head_addr_q <= bus.wr_addr;
            head_we_q   <= new_we;
        end else if (load_head_tail) begin
            head_data_q <= tail_data_q;
            head_addr_q <= tail_addr_q;
            head_we_q   <= tail_we_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tail_data_q <= '0;
            tail_addr_q <= '0;
            tail_we_q   <= 1'b0;
        end else if (load_tail) begin
            tail_data_q <= bus.rslt;
            tail_addr_q <= bus.wr_addr;
            tail_we_q   <= new_we;
        end
    end

    // Status is captured at accept time so the ALU sees its own carry next op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 3'b000;
            sc_q    <= 1'b0;
        end else if (accept) begin
            if (bus.alu_cmd != CMD_NOP) begin
                flags_q <= {bus.pari, bus.zero, bus.neq};
            end
            if (!bus.alu_cmd[1]) begin
                sc_q <= bus.sc_o;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt_q <= 8'd0;
        end else if (drain) begin
            retire_cnt_q <= retire_cnt_q + 8'd1;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_data  = head_data_q;
    assign bus.out_addr  = head_addr_q;
    assign bus.out_we    = head_we_q;
    assign retire_cnt    = retire_cnt_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb/tb_alu_wb_stage.sv - randomized and directed bench for alu_wb_stage against a queue model
module tb_alu_wb_stage;

    localparam int DW = 6;
    localparam int AW = 3;

    logic          clk;
    logic          reset;
    logic          sc_q;
    logic [2:0]    flags_q;
    logic [7:0]    retire_cnt;

    alu_wb_stage_if #(.DW(DW), .AW(AW)) bus ();

    alu_wb_stage #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .sc_q       (sc_q),
        .flags_q    (flags_q),
        .retire_cnt (retire_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          we;
    } ent_t;

    ent_t       mq[$];
    logic [2:0] m_flags;
    logic       m_sc;
    logic [7:0] m_cnt;
    logic       m_rdy;
    int         n_checks;
    int         n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("in_ready", 32'(bus.in_ready), 32'(m_rdy));
        check("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("out_data", 32'(bus.out_data), 32'(mq[0].d));
            check("out_addr", 32'(bus.out_addr), 32'(mq[0].a));
            check("out_we", 32'(bus.out_we), 32'(mq[0].we));
        end
        check("sc_q", 32'(sc_q), 32'(m_sc));
        check("flags_q", 32'(flags_q), 32'(m_flags));
        check("retire_cnt", 32'(retire_cnt), 32'(m_cnt));
    endtask

    // Called at a falling edge: drive one cycle of inputs, advance the model
    // across the coming rising edge, then check at the next falling edge.
    task automatic step(input logic v, input logic [1:0] cmd, input logic [DW-1:0] r,
                        input logic sc, input logic [2:0] fl, input logic [AW-1:0] a,
                        input logic en, input logic ordy);
        logic acc;
        logic drn;
        ent_t e;
        bus.in_valid  = v;
        bus.alu_cmd   = cmd;
        bus.rslt      = r;
        bus.sc_o      = sc;
        bus.pari      = fl[2];
        bus.zero      = fl[1];
        bus.neq       = fl[0];
        bus.wr_addr   = a;
        bus.wr_en     = en;
        bus.out_ready = ordy;
        acc = v && m_rdy;
        drn = (mq.size() > 0) && ordy;
        if (drn) begin
            void'(mq.pop_front());
            m_cnt = m_cnt + 8'd1;
        end
        if (acc) begin
            e.d  = r;
            e.a  = a;
            e.we = en && (cmd != 2'b11);
            mq.push_back(e);
            if (cmd != 2'b11) m_flags = fl;
            if (cmd == 2'b00 || cmd == 2'b01) m_sc = sc;
        end
        m_rdy = (mq.size() < 2);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 2'($urandom_range(0, 3)), DW'($urandom), 1'($urandom), 3'($urandom),
             AW'($urandom), 1'($urandom), ordy);
    endtask

    task automatic rand_step();
        step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), DW'($urandom),
             1'($urandom), 3'($urandom), AW'($urandom), 1'($urandom),
             1'($urandom_range(0, 2) != 0));
    endtask

    // Asserted just after a falling edge; outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_addr", 32'(bus.out_addr), 32'd0);
        check("rst_out_we", 32'(bus.out_we), 32'd0);
        check("rst_sc_q", 32'(sc_q), 32'd0);
        check("rst_flags_q", 32'(flags_q), 32'd0);
        check("rst_retire_cnt", 32'(retire_cnt), 32'd0);
        mq.delete();
        m_flags = 3'b000;
        m_sc    = 1'b0;
        m_cnt   = 8'd0;
        m_rdy   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_all();
        idle(1'b0);
    endtask

    int cnt_before;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_cmd   = 2'b00;
        bus.rslt      = '0;
        bus.sc_o      = 1'b0;
        bus.pari      = 1'b0;
        bus.zero      = 1'b0;
        bus.neq       = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_en     = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // add with carry, single-cycle latency, then drain
        step(1'b1, 2'b00, 6'b011101, 1'b1, 3'b000, 3'd5, 1'b1, 1'b1);
        check("r38_valid", 32'(bus.out_valid), 32'd1);
        check("r38_data", 32'(bus.out_data), 32'h1d);
        check("r38_addr", 32'(bus.out_addr), 32'd5);
        check("r38_we", 32'(bus.out_we), 32'd1);
        check("r38_sc", 32'(sc_q), 32'd1);
        idle(1'b1);
        check("r38_cnt", 32'(retire_cnt), 32'd1);

        // back-to-back accepts with a stalled sink: third is dropped
        step(1'b1, 2'b00, 6'd1, 1'b0, 3'b000, 3'd1, 1'b1, 1'b0);
        step(1'b1, 2'b00, 6'd2, 1'b0, 3'b000, 3'd2, 1'b1, 1'b0);
        check("r39_ready_b", 32'(bus.in_ready), 32'd0);
        step(1'b1, 2'b00, 6'd3, 1'b1, 3'b111, 3'd3, 1'b1, 1'b0);
        check("r39_hold_a", 32'(bus.out_data), 32'd1);
        check("r39_flags_c", 32'(flags_q), 32'd0);
        idle(1'b1);
        check("r39_then_b", 32'(bus.out_data), 32'd2);
        idle(1'b1);
        check("r39_empty", 32'(bus.out_valid), 32'd0);

        // nand keeps carry, updates flags; nop touches neither and never writes
        step(1'b1, 2'b00, 6'd7, 1'b1, 3'b010, 3'd1, 1'b1, 1'b1);
        step(1'b1, 2'b10, 6'd8, 1'b0, 3'b101, 3'd2, 1'b1, 1'b1);
        check("r40_sc", 32'(sc_q), 32'd1);
        check("r40_flags", 32'(flags_q), 32'd5);
        step(1'b1, 2'b11, 6'd9, 1'b0, 3'b100, 3'd3, 1'b1, 1'b1);
        check("r41_we", 32'(bus.out_we), 32'd0);
        check("r41_flags", 32'(flags_q), 32'd5);
        check("r41_sc", 32'(sc_q), 32'd1);

        // steady accept+drain in ONE for 10 cycles
        cnt_before = int'(retire_cnt);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 2'($urandom_range(0, 3)), DW'(i + 20), 1'($urandom), 3'($urandom),
                 AW'(i), 1'b1, 1'b1);
            check("r42_one_valid", 32'(bus.out_valid), 32'd1);
            check("r42_one_ready", 32'(bus.in_ready), 32'd1);
        end
        check("r42_cnt", 32'(retire_cnt), 32'((cnt_before + 10) % 256));

        // drive to retire_cnt=255, fill, then reset asynchronously
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 2'b01, DW'($urandom), 1'($urandom), 3'($urandom), AW'($urandom),
                 1'($urandom), 1'b1);
        end
        check("r43_cnt255", 32'(retire_cnt), 32'd255);
        step(1'b1, 2'b00, 6'd4, 1'b0, 3'b001, 3'd4, 1'b1, 1'b0);
        check("r43_full", 32'(bus.in_ready), 32'd0);
        do_reset();

        // 256 drains from reset wrap the counter
        for (int i = 0; i < 257; i++) begin
            step(1'b1, 2'b00, DW'($urandom), 1'($urandom), 3'($urandom), AW'($urandom),
                 1'b1, 1'b1);
        end
        check("r43_wrap", 32'(retire_cnt), 32'd0);

        // random traffic with a reset in the middle
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            rand_step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
